elevator_call_dispatcher: RTL and testbench

Reads the per-floor latched call bits produced by the elevator's request flip-flops and serves them with a SCAN policy. Drives the motor and the door, tracks the current floor, and returns a one-cycle clear pulse to each call latch it serves. Sits between the call-latch bank (writer side) and the motor/door outputs of the elevator top level.

---
 rtl/elevator_call_dispatcher_if.sv | 38 +++
 rtl/elevator_call_dispatcher.sv | 160 ++++++++++++++++
 tb/tb_elevator_call_dispatcher.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/elevator_call_dispatcher_if.sv
// Call-latch / motor / door bundle between the elevator top level and the dispatcher.
// The dispatcher uses the master side; the call-latch bank and actuators use the slave side.
interface elevator_call_dispatcher_if #(
    parameter int FLOORS = 4
);
    localparam int FW = $clog2(FLOORS);

    logic [FLOORS-1:0] call_pending;
    logic [FLOORS-1:0] call_clear;
    logic [FW-1:0]     floor;
    logic              dir_up;
    logic              motor_up;
    logic              motor_down;
    logic              door_open;
    logic              busy;

    modport master (
        input  call_pending,
        output call_clear,
        output floor,
        output dir_up,
        output motor_up,
        output motor_down,
        output door_open,
        output busy
    );

    modport slave (
        output call_pending,
        input  call_clear,
        input  floor,
        input  dir_up,
        input  motor_up,
        input  motor_down,
        input  door_open,
        input  busy
    );
endinterface

// File: rtl/elevator_call_dispatcher.sv
// SCAN-policy elevator dispatcher: serves latched floor calls, drives motor and door, clears served latches.
// Optional feature macro DOOR_HOLD_EN: a same-floor call while the door is open reopens it.
module elevator_call_dispatcher #(
    parameter int FLOORS        = 4,
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 5
) (
    input  logic clk,
    input  logic preset,
    elevator_call_dispatcher_if.master bus
);
    // state     | meaning
    // IDLE      | parked at floor, evaluating pending calls
    // MOVING    | motor on in dir_up, travel counter running
    // DOOR_OPEN | door open at floor, door counter running
    localparam int FW = $clog2(FLOORS);
    localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, MOVING, DOOR_OPEN} state_t;

    state_t            state_q, state_d;
    logic [FW-1:0]     floor_q, floor_d;
    logic              dir_q, dir_d;
    logic [TW-1:0]     travel_q, travel_d;
    logic [DW-1:0]     door_q, door_d;
    logic [FLOORS-1:0] clear_q, clear_d;
    logic              motor_up_q, motor_up_d;
    logic              motor_down_q, motor_down_d;
    logic              door_open_q, door_open_d;
    logic              busy_q, busy_d;

    logic              here_call, ahead, behind;
    logic              travel_tc, door_tc;
    logic [FW-1:0]     next_floor;
    logic              arrive_call, further;
    logic              reopen;

    function automatic logic any_ahead(input logic [FLOORS-1:0] calls,
                                       input logic [FW-1:0] f,
                                       input logic up);
        any_ahead = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (calls[i] && (up ? (i > int'(f)) : (i < int'(f))))
                any_ahead = 1'b1;
        end
    endfunction

    assign here_call   = bus.call_pending[floor_q];
    assign ahead       = any_ahead(bus.call_pending, floor_q, dir_q);
    assign behind      = any_ahead(bus.call_pending, floor_q, ~dir_q);
    assign travel_tc   = (travel_q == TW'(TRAVEL_CYCLES - 1));
    assign door_tc     = (door_q == DW'(DOOR_CYCLES - 1));
    assign next_floor  = dir_q ? floor_q + FW'(1) : floor_q - FW'(1);
    assign arrive_call = bus.call_pending[next_floor];
    assign further     = any_ahead(bus.call_pending, next_floor, dir_q);

`ifdef DOOR_HOLD_EN
    // A pending bit seen while its clear pulse is still out is the call just served.
    assign reopen = here_call && !clear_q[floor_q];
`else
    assign reopen = 1'b0;
`endif

    always_ff @(posedge clk or posedge preset) begin
        if (preset) begin
            state_q      <= IDLE;
            floor_q      <= '0;
            dir_q        <= 1'b1;
            travel_q     <= '0;
            door_q       <= '0;
            clear_q      <= '0;
            motor_up_q   <= 1'b0;
            motor_down_q <= 1'b0;
            door_open_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            floor_q      <= floor_d;
            dir_q        <= dir_d;
            travel_q     <= travel_d;
            door_q       <= door_d;
            clear_q      <= clear_d;
            motor_up_q   <= motor_up_d;
            motor_down_q <= motor_down_d;
            door_open_q  <= door_open_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (here_call)
                    state_d = DOOR_OPEN;
                else if (ahead || behind)
                    state_d = MOVING;
            end
            MOVING: begin
                if (travel_tc) begin
                    if (arrive_call)
                        state_d = DOOR_OPEN;
                    else if (!further)
                        state_d = IDLE;
                end
            end
            DOOR_OPEN: begin
                if (!reopen && door_tc)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs are derived from the state being entered so they line up with it.
    always_comb begin
        floor_d  = floor_q;
        dir_d    = dir_q;
        travel_d = '0;
        door_d   = '0;
        clear_d  = '0;
        case (state_q)
            IDLE: begin
                if (here_call)
                    clear_d = FLOORS'(1) << floor_q;
                else if (!ahead && behind)
                    dir_d = ~dir_q;
            end
            MOVING: begin
                if (travel_tc) begin
                    floor_d = next_floor;
                    if (arrive_call)
                        clear_d = FLOORS'(1) << next_floor;
                end else begin
                    travel_d = travel_q + TW'(1);
                end
            end
            DOOR_OPEN: begin
                if (reopen)
                    clear_d = FLOORS'(1) << floor_q;
                else if (!door_tc)
                    door_d = door_q + DW'(1);
            end
            default: ;
        endcase
        motor_up_d   = (state_d == MOVING) && dir_d;
        motor_down_d = (state_d == MOVING) && !dir_d;
        door_open_d  = (state_d == DOOR_OPEN);
        busy_d       = (state_d != IDLE);
    end

    assign bus.call_clear = clear_q;
    assign bus.floor      = floor_q;
    assign bus.dir_up     = dir_q;
    assign bus.motor_up   = motor_up_q;
    assign bus.motor_down = motor_down_q;
    assign bus.door_open  = door_open_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_elevator_call_dispatcher.sv
// Directed bench for elevator_call_dispatcher: vector table plus reset and door-hold sequences.
module tb_elevator_call_dispatcher;
    logic clk;
    logic preset;
    int   errors = 0;
    int   checks = 0;

    elevator_call_dispatcher_if #(.FLOORS(4)) bus ();

    elevator_call_dispatcher #(
        .FLOORS(4),
        .TRAVEL_CYCLES(8),
        .DOOR_CYCLES(5)
    ) dut (
        .clk(clk),
        .preset(preset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {floor, dir_up, motor_up, motor_down, door_open, busy, call_clear}
    logic [10:0] obs;
    assign obs = {bus.floor, bus.dir_up, bus.motor_up, bus.motor_down,
                  bus.door_open, bus.busy, bus.call_clear};

    typedef struct {
        logic [3:0]  clr;
        logic [3:0]  set;
        int          n;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[26];

    function automatic logic [10:0] ex(input logic [1:0] f, input logic d, input logic mu,
                                       input logic md, input logic door, input logic bsy,
                                       input logic [3:0] clr);
        return {f, d, mu, md, door, bsy, clr};
    endfunction

    task automatic check(input string nm, input logic [10:0] got, input logic [10:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%b want=%b (floor,dir,mu,md,door,busy,clear)", nm, got, want);
        end
    endtask

    // One clock; the call latches then drop any bit whose clear pulse is out.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.call_pending = bus.call_pending & ~bus.call_clear;
    endtask

    initial begin
        preset           = 1'b0;
        bus.call_pending = 4'b0000;

        // Async reset between edges
        #2 preset = 1'b1;
        #1 check("reset_async", obs, ex(2'd0, 1, 0, 0, 0, 0, 4'b0000));
        @(negedge clk);
        preset = 1'b0;

        // Door hold / reopen at floor 0
        bus.call_pending = 4'b0001;
        tick();
        check("hold_entry", obs, ex(2'd0, 1, 0, 0, 1, 1, 4'b0001));
        tick();
        tick();
        bus.call_pending = bus.call_pending | 4'b0001;
        tick();
`ifdef DOOR_HOLD_EN
        check("hold_retrigger", obs, ex(2'd0, 1, 0, 0, 1, 1, 4'b0001));
        tick();
        check("hold_k4", obs, ex(2'd0, 1, 0, 0, 1, 1, 4'b0000));
        repeat (3) tick();
        check("hold_k7_open", obs, ex(2'd0, 1, 0, 0, 1, 1, 4'b0000));
        tick();
        check("hold_k8_closed", obs, ex(2'd0, 1, 0, 0, 0, 0, 4'b0000));
`else
        check("hold_ignored", obs, ex(2'd0, 1, 0, 0, 1, 1, 4'b0000));
        tick();
        check("hold_k4", obs, ex(2'd0, 1, 0, 0, 1, 1, 4'b0000));
        tick();
        check("hold_k5_closed", obs, ex(2'd0, 1, 0, 0, 0, 0, 4'b0000));
        tick();
        check("hold_k6_reopen", obs, ex(2'd0, 1, 0, 0, 1, 1, 4'b0001));
        repeat (4) tick();
        check("hold_k10_open", obs, ex(2'd0, 1, 0, 0, 1, 1, 4'b0000));
        tick();
        check("hold_k11_closed", obs, ex(2'd0, 1, 0, 0, 0, 0, 4'b0000));
`endif

        // clr, set, cycles, expected outputs after those cycles
        vecs[0]  = '{4'b0000, 4'b0000, 1, ex(2'd0, 1, 0, 0, 0, 0, 4'b0000)};
        vecs[1]  = '{4'b0000, 4'b0001, 1, ex(2'd0, 1, 0, 0, 1, 1, 4'b0001)};
        vecs[2]  = '{4'b0000, 4'b0000, 1, ex(2'd0, 1, 0, 0, 1, 1, 4'b0000)};
        vecs[3]  = '{4'b0000, 4'b0000, 3, ex(2'd0, 1, 0, 0, 1, 1, 4'b0000)};
        vecs[4]  = '{4'b0000, 4'b0000, 1, ex(2'd0, 1, 0, 0, 0, 0, 4'b0000)};
        vecs[5]  = '{4'b0000, 4'b0100, 1, ex(2'd0, 1, 1, 0, 0, 1, 4'b0000)};
        vecs[6]  = '{4'b0000, 4'b0000, 7, ex(2'd0, 1, 1, 0, 0, 1, 4'b0000)};
        vecs[7]  = '{4'b0000, 4'b0000, 1, ex(2'd1, 1, 1, 0, 0, 1, 4'b0000)};
        vecs[8]  = '{4'b0000, 4'b0000, 7, ex(2'd1, 1, 1, 0, 0, 1, 4'b0000)};
        vecs[9]  = '{4'b0000, 4'b0000, 1, ex(2'd2, 1, 0, 0, 1, 1, 4'b0100)};
        vecs[10] = '{4'b0000, 4'b0000, 1, ex(2'd2, 1, 0, 0, 1, 1, 4'b0000)};
        vecs[11] = '{4'b0000, 4'b0000, 4, ex(2'd2, 1, 0, 0, 0, 0, 4'b0000)};
        vecs[12] = '{4'b0000, 4'b1010, 1, ex(2'd2, 1, 1, 0, 0, 1, 4'b0000)};
        vecs[13] = '{4'b0000, 4'b0000, 8, ex(2'd3, 1, 0, 0, 1, 1, 4'b1000)};
        vecs[14] = '{4'b0000, 4'b0000, 5, ex(2'd3, 1, 0, 0, 0, 0, 4'b0000)};
        vecs[15] = '{4'b0000, 4'b0000, 1, ex(2'd3, 0, 0, 1, 0, 1, 4'b0000)};
        vecs[16] = '{4'b0000, 4'b0000, 8, ex(2'd2, 0, 0, 1, 0, 1, 4'b0000)};
        vecs[17] = '{4'b0000, 4'b0000, 7, ex(2'd2, 0, 0, 1, 0, 1, 4'b0000)};
        vecs[18] = '{4'b0000, 4'b0000, 1, ex(2'd1, 0, 0, 0, 1, 1, 4'b0010)};
        vecs[19] = '{4'b0000, 4'b0000, 5, ex(2'd1, 0, 0, 0, 0, 0, 4'b0000)};
        vecs[20] = '{4'b0000, 4'b1001, 1, ex(2'd1, 0, 0, 1, 0, 1, 4'b0000)};
        vecs[21] = '{4'b0000, 4'b0000, 8, ex(2'd0, 0, 0, 0, 1, 1, 4'b0001)};
        vecs[22] = '{4'b0000, 4'b0000, 5, ex(2'd0, 0, 0, 0, 0, 0, 4'b0000)};
        vecs[23] = '{4'b0000, 4'b0000, 1, ex(2'd0, 1, 1, 0, 0, 1, 4'b0000)};
        vecs[24] = '{4'b0000, 4'b0000, 8, ex(2'd1, 1, 1, 0, 0, 1, 4'b0000)};
        vecs[25] = '{4'b1000, 4'b0000, 8, ex(2'd2, 1, 0, 0, 0, 0, 4'b0000)};

        for (int i = 0; i < 26; i++) begin
            bus.call_pending = (bus.call_pending & ~vecs[i].clr) | vecs[i].set;
            repeat (vecs[i].n) tick();
            check($sformatf("vec%0d", i), obs, vecs[i].exp);
        end

        // Reset in the middle of a move
        bus.call_pending = 4'b0001;
        tick();
        repeat (4) tick();
        check("premove", obs, ex(2'd2, 0, 0, 1, 0, 1, 4'b0000));
        #2 preset = 1'b1;
        #1 check("reset_midmove", obs, ex(2'd0, 1, 0, 0, 0, 0, 4'b0000));
        bus.call_pending = 4'b0000;
        @(negedge clk);
        preset = 1'b0;
        tick();
        tick();
        check("post_reset_quiet", obs, ex(2'd0, 1, 0, 0, 0, 0, 4'b0000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
